// File: rtl/cm_arb.sv
// N-to-1 valid/ready arbiter with registered output; ALGO picks MIN/MAX/round-robin.
// Optional packet lock (grant held from first beat to i_last) under CM_ARB_PKT_LOCK_EN.
package cm_pkg;
  typedef enum logic [1:0] {
    ARB_MIN,
    ARB_MAX,
    ARB_RR
  } t_arb_algo;
endpackage

module cm_arb #(
  parameter int unsigned       REQ_CNT = 4,
  parameter int unsigned       DATA_W  = 32,
  parameter cm_pkg::t_arb_algo ALGO    = cm_pkg::ARB_RR,
  localparam int unsigned      IDX_W   = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REQ_CNT-1:0]          i_vld,
  input  logic [REQ_CNT*DATA_W-1:0]   i_dat,
  input  logic [REQ_CNT-1:0]          i_last,
  output logic [REQ_CNT-1:0]          o_rdy,
  output logic                        o_vld,
  output logic [DATA_W-1:0]           o_dat,
  output logic [IDX_W-1:0]            o_idx,
  output logic                        o_last,
  input  logic                        i_rdy
);

  logic [REQ_CNT-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               found;
  logic [DATA_W-1:0]  dat_sel;
  logic               last_sel;
  logic               slot_free;
  logic               accept;
  logic [IDX_W-1:0]   ptr_next;

  logic               vld_q, vld_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`ifdef CM_ARB_PKT_LOCK_EN
  logic               lock_q, lock_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
`endif

  // i-th candidate in search order for the configured algorithm
  function automatic logic [IDX_W-1:0] cand(input int unsigned i, input logic [IDX_W-1:0] p);
    int unsigned c;
    if (ALGO == cm_pkg::ARB_MIN)      c = i;
    else if (ALGO == cm_pkg::ARB_MAX) c = REQ_CNT - 1 - i;
    else                              c = (32'(p) + i) % REQ_CNT;
    return IDX_W'(c);
  endfunction

  always_comb begin
    grant    = '0;
    win_idx  = '0;
    cand_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      cand_idx = cand(i, ptr_q);
      if (!found && i_vld[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        win_idx         = cand_idx;
        found           = 1'b1;
      end
    end
`ifdef CM_ARB_PKT_LOCK_EN
    if (lock_q) begin
      grant             = '0;
      grant[lock_idx_q] = 1'b1;
      win_idx           = lock_idx_q;
    end
`endif
  end

  always_comb begin
    dat_sel = '0;
    for (int unsigned k = 0; k < REQ_CNT; k++) begin
      if (grant[k]) dat_sel = i_dat[k*DATA_W +: DATA_W];
    end
  end

  assign last_sel  = i_last[win_idx];
  assign slot_free = !vld_q | i_rdy;
  assign o_rdy     = grant & {REQ_CNT{slot_free}};
  assign accept    = |(i_vld & o_rdy);
  assign ptr_next  = (win_idx == IDX_W'(REQ_CNT - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    idx_d  = idx_q;
    last_d = last_q;
    ptr_d  = ptr_q;
    if (accept) begin
      vld_d  = 1'b1;
      dat_d  = dat_sel;
      idx_d  = win_idx;
      last_d = last_sel;
    end else if (i_rdy) begin
      vld_d = 1'b0;
    end
`ifdef CM_ARB_PKT_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      lock_d     = !last_sel;
      lock_idx_d = win_idx;
    end
    // pointer moves only when a packet completes, so the next packet rotates fairly
    if (accept && last_sel && ALGO == cm_pkg::ARB_RR) ptr_d = ptr_next;
`else
    if (accept && ALGO == cm_pkg::ARB_RR) ptr_d = ptr_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= 1'b0;
      dat_q      <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      ptr_q      <= '0;
`ifdef CM_ARB_PKT_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      ptr_q      <= ptr_d;
`ifdef CM_ARB_PKT_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  assign o_vld  = vld_q;
  assign o_dat  = dat_q;
  assign o_idx  = idx_q;
  assign o_last = last_q;

endmodule

// File: tb/tb_cm_arb.sv
// Directed bench for cm_arb: round-robin instance checked through a beat scoreboard,
// plus ARB_MIN and REQ_CNT=1 instances checked directly.
module tb_cm_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // round-robin, REQ_CNT=4
  logic [3:0]   rr_vld, rr_last, rr_ordy;
  logic [127:0] rr_dat;
  logic         rr_ovld, rr_olast, rr_irdy;
  logic [31:0]  rr_odat;
  logic [1:0]   rr_oidx;
  // fixed priority lowest-index, REQ_CNT=4
  logic [3:0]   mn_vld, mn_last, mn_ordy;
  logic [127:0] mn_dat;
  logic         mn_ovld, mn_olast, mn_irdy;
  logic [31:0]  mn_odat;
  logic [1:0]   mn_oidx;
  // single requester
  logic [0:0]   o1_vld, o1_last, o1_ordy, o1_oidx;
  logic [7:0]   o1_dat, o1_odat;
  logic         o1_ovld, o1_olast, o1_irdy;

  cm_arb #(.REQ_CNT(4), .DATA_W(32), .ALGO(cm_pkg::ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .i_vld(rr_vld), .i_dat(rr_dat), .i_last(rr_last),
    .o_rdy(rr_ordy), .o_vld(rr_ovld), .o_dat(rr_odat), .o_idx(rr_oidx),
    .o_last(rr_olast), .i_rdy(rr_irdy));

  cm_arb #(.REQ_CNT(4), .DATA_W(32), .ALGO(cm_pkg::ARB_MIN)) u_min (
    .clk(clk), .rst_n(rst_n), .i_vld(mn_vld), .i_dat(mn_dat), .i_last(mn_last),
    .o_rdy(mn_ordy), .o_vld(mn_ovld), .o_dat(mn_odat), .o_idx(mn_oidx),
    .o_last(mn_olast), .i_rdy(mn_irdy));

  cm_arb #(.REQ_CNT(1), .DATA_W(8), .ALGO(cm_pkg::ARB_RR)) u_one (
    .clk(clk), .rst_n(rst_n), .i_vld(o1_vld), .i_dat(o1_dat), .i_last(o1_last),
    .o_rdy(o1_ordy), .o_vld(o1_ovld), .o_dat(o1_odat), .o_idx(o1_oidx),
    .o_last(o1_olast), .i_rdy(o1_irdy));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] dat;
    logic        last;
  } beat_t;
  beat_t sb[$];
  beat_t exp_b;

  function automatic logic [31:0] dat_of(input int k, input int c);
    return {4'hA, 4'(k), 24'(c)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      rr_dat[k*32 +: 32] = dat_of(k, cyc);
      mn_dat[k*32 +: 32] = dat_of(k, cyc);
    end
    o1_dat = 8'(cyc);
  endtask

  task automatic rr_drive(input logic [3:0] vld, input logic rdy, input logic [3:0] last);
    tick();
    rr_vld  = vld;
    rr_irdy = rdy;
    rr_last = last;
    #2;
  endtask

  task automatic push(input int idx, input logic last);
    sb.push_back({2'(idx), dat_of(idx, cyc), last});
  endtask

  // a beat leaves the arbiter on the next rising edge when o_vld & i_rdy
  always @(negedge clk) begin
    if (rst_n && rr_ovld && rr_irdy) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_empty: observed beat idx %0d expected none", rr_oidx);
      end
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        chk("sb_beat", {rr_oidx, rr_odat, rr_olast}, exp_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  int rr_seq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0;
    rr_vld = '0; rr_last = '0; rr_dat = '0; rr_irdy = 1'b1;
    mn_vld = '0; mn_last = '0; mn_dat = '0; mn_irdy = 1'b1;
    o1_vld = '0; o1_last = '0; o1_dat = '0; o1_irdy = 1'b1;
    #3;
    chk("rst_vld", rr_ovld, 0);
    chk("rst_dat", rr_odat, 0);
    chk("rst_idx", rr_oidx, 0);
    chk("rst_last", rr_olast, 0);

    tick(); rst_n = 1'b1; #2;
    for (int i = 0; i < 3; i++) begin
      rr_drive(4'b0000, 1'b1, 4'b0000);
      chk("idle_vld", rr_ovld, 0);
      chk("idle_dat", rr_odat, 0);
      chk("idle_idx", rr_oidx, 0);
      chk("idle_rdy", rr_ordy, 0);
    end

    // round-robin, all requesters valid
    for (int i = 0; i < 6; i++) begin
      rr_drive(4'b1111, 1'b1, 4'b0000);
      chk("rr_rdy", rr_ordy, 4'b0001 << rr_seq[i]);
      if (i > 0) chk("rr_vld", rr_ovld, 1);
      push(rr_seq[i], 1'b0);
    end
    rr_drive(4'b0000, 1'b1, 4'b0000);
    chk("rr_tail_vld", rr_ovld, 1);
    rr_drive(4'b0000, 1'b1, 4'b0000);
    chk("drain_vld", rr_ovld, 0);

    // backpressure, pointer at 2
    rr_drive(4'b1111, 1'b1, 4'b0000);
    chk("bp_first_rdy", rr_ordy, 4'b0100);
    push(2, 1'b0);
    acc_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      rr_drive(4'b1111, 1'b0, 4'b0000);
      chk("bp_rdy", rr_ordy, 0);
      chk("bp_vld", rr_ovld, 1);
      chk("bp_dat", rr_odat, dat_of(2, acc_cyc));
      chk("bp_idx", rr_oidx, 2);
    end
    rr_drive(4'b1111, 1'b1, 4'b0000);
    chk("bp_release_rdy", rr_ordy, 4'b1000);
    push(3, 1'b0);
    rr_drive(4'b1111, 1'b1, 4'b0000);
    chk("bp_wrap_rdy", rr_ordy, 4'b0001);
    push(0, 1'b0);

    // sparse requests across the wrap
    rr_drive(4'b0100, 1'b1, 4'b0000);
    chk("sp_rdy0", rr_ordy, 4'b0100);
    push(2, 1'b0);
    rr_drive(4'b0101, 1'b1, 4'b0000);
    chk("sp_wrap_rdy", rr_ordy, 4'b0001);
    push(0, 1'b0);
    rr_drive(4'b0101, 1'b1, 4'b0000);
    chk("sp_next_rdy", rr_ordy, 4'b0100);
    push(2, 1'b0);
    rr_drive(4'b0000, 1'b1, 4'b0000);
    rr_drive(4'b0000, 1'b1, 4'b0000);
    chk("sp_drain_vld", rr_ovld, 0);

`ifdef CM_ARB_PKT_LOCK_EN
    // 3-beat packet from req0 with a bubble; req1 waits throughout
    rr_drive(4'b0011, 1'b1, 4'b0000);
    chk("lk_b1_rdy", rr_ordy, 4'b0001);
    push(0, 1'b0);
    rr_drive(4'b0010, 1'b1, 4'b0000);
    chk("lk_bubble_rdy", rr_ordy, 4'b0001);
    rr_drive(4'b0011, 1'b1, 4'b0000);
    chk("lk_b2_rdy", rr_ordy, 4'b0001);
    push(0, 1'b0);
    rr_drive(4'b0011, 1'b1, 4'b0001);
    chk("lk_b3_rdy", rr_ordy, 4'b0001);
    push(0, 1'b1);
    rr_drive(4'b0010, 1'b1, 4'b0000);
    chk("lk_after_rdy", rr_ordy, 4'b0010);
    push(1, 1'b0);
    rr_drive(4'b0000, 1'b1, 4'b0000);
    rr_drive(4'b0000, 1'b1, 4'b0000);
    chk("lk_drain_vld", rr_ovld, 0);
`endif

    // reset while a beat is in flight, then pointer must restart at 0
    rr_drive(4'b0001, 1'b1, 4'b0000);
    push(0, 1'b0);
    tick();
    rr_vld = 4'b1111;
    rst_n  = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_vld", rr_ovld, 0);
    chk("rst_mid_dat", rr_odat, 0);
    tick(); rr_vld = 4'b0000; rst_n = 1'b1; #2;
    chk("post_rst_vld", rr_ovld, 0);
    chk("post_rst_rdy", rr_ordy, 0);
    chk("post_rst_idx", rr_oidx, 0);
    rr_drive(4'b0110, 1'b1, 4'b0000);
    chk("ptr_rst_rdy", rr_ordy, 4'b0010);
    push(1, 1'b0);
    rr_drive(4'b0000, 1'b1, 4'b0000);
    rr_drive(4'b0000, 1'b1, 4'b0000);
    chk("ptr_rst_drain", rr_ovld, 0);

    // lowest-index fixed priority
    tick(); mn_vld = 4'b1010; #2;
    chk("min_rdy_a", mn_ordy, 4'b0010);
    tick(); mn_vld = 4'b1000; #2;
    chk("min_vld_a", mn_ovld, 1);
    chk("min_idx_a", mn_oidx, 1);
    chk("min_dat_a", mn_odat, dat_of(1, cyc - 1));
    chk("min_rdy_b", mn_ordy, 4'b1000);
    tick(); mn_vld = 4'b0000; #2;
    chk("min_idx_b", mn_oidx, 3);
    chk("min_dat_b", mn_odat, dat_of(3, cyc - 1));
    chk("min_rdy_idle", mn_ordy, 0);

    // single requester
    tick(); o1_vld = 1'b1; #2;
    chk("one_rdy", o1_ordy, 1);
    acc_cyc = cyc;
    tick(); o1_vld = 1'b0; #2;
    chk("one_vld", o1_ovld, 1);
    chk("one_idx", o1_oidx, 0);
    chk("one_dat", o1_odat, 8'(acc_cyc));
    chk("one_rdy_idle", o1_ordy, 0);

    tick(); #2;
    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cm_arb.md
Name: cm_arb

Overview:
- Parametrised N-to-1 valid/ready arbiter with a registered output stage, used in lib_cm wherever several streams share one sink.
- Selection algorithm is chosen by a parameter of type cm_pkg::t_arb_algo.
- cm_pkg gains the enum value ARB_RR (round-robin), appended after ARB_MAX.
- The selected input's payload and its index are forwarded one cycle after acceptance, at full throughput.

Parameters:
- REQ_CNT, 4, number of requesters; must be 1 or more.
- DATA_W, 32, payload width per requester.
- ALGO, cm_pkg::ARB_RR, selection algorithm:
  - ARB_MIN: lowest index wins.
  - ARB_MAX: highest index wins.
  - ARB_RR: round-robin.
- IDX_W, max($clog2(REQ_CNT),1), derived width of the index output; not to be overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_vld  in  REQ_CNT  per-requester valid.
- i_dat  in  REQ_CNT*DATA_W  packed payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- i_last  in  REQ_CNT  per-requester end-of-packet; used only with CM_ARB_PKT_LOCK_EN.
- o_rdy  out  REQ_CNT  per-requester ready.
- o_vld  out  1  output valid.
- o_dat  out  DATA_W  output payload.
- o_idx  out  IDX_W  index of the requester that supplied o_dat.
- o_last  out  1  forwarded i_last of the granted beat.
- i_rdy  in  1  sink ready.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - o_vld=0, o_dat=0, o_idx=0, o_last=0.
  - Round-robin pointer=0.
  - Lock state cleared.
  - o_rdy is combinational and reads 0 while o_vld=0 and no request is pending.
- Slot free: slot_free = !o_vld | i_rdy.
- Grant: a one-hot grant vector is computed combinationally from i_vld, ALGO and the pointer.
  - o_rdy[k] = grant[k] & slot_free.
  - At most one o_rdy bit is high in any cycle.
- Accept: on a beat where i_vld[k] & o_rdy[k], the output register loads i_dat[k], k and i_last[k] with o_vld=1, visible next cycle. Latency is exactly 1 cycle.
- Drain: if o_vld & i_rdy and no input is accepted in that cycle, o_vld goes to 0.
- Simultaneous drain and accept: the register reloads and o_vld stays 1. Sustained throughput is 1 beat/cycle.
- Output stability: while o_vld & !i_rdy, o_dat/o_idx/o_last hold stable and all o_rdy are 0.
- ARB_RR:
  - Search starts at pointer p and wraps modulo REQ_CNT.
  - After an accepted beat from k, p <= (k+1) mod REQ_CNT; wrap from REQ_CNT-1 goes to 0.
  - Pointer is unchanged on cycles with no accept.
- ARB_MIN / ARB_MAX: fixed priority with no state; the pointer is unused.
- Request stability: requesters must not drop i_vld before their own handshake. The arbiter does not hold a grant across stalls; the grant is recomputed every cycle.
- REQ_CNT=1: grant[0]=i_vld[0] and o_idx is constant 0.
- No valid inputs: grant=0, and the register drains normally.
- Reset mid-transfer: the output beat is discarded (o_vld=0) and the pointer returns to 0.

Optional Feature:
- Macro: CM_ARB_PKT_LOCK_EN.
- Defined:
  - After accepting a beat from k with i_last[k]=0, the arbiter locks onto k.
  - While locked, grant=one-hot(k) regardless of ALGO, even if i_vld[k]=0 (bubbles allowed).
  - The lock releases on the accepted beat with i_last[k]=1.
  - The ARB_RR pointer advances only on that releasing beat.
  - Reset clears the lock.
- Not defined:
  - i_last is forwarded to o_last only.
  - Arbitration is per beat and the lock logic is absent.

Test Plan:
- Reset and idle: rst_n=0 during traffic, then release with i_vld=0 -> o_vld=0, o_dat=0, o_idx=0, o_rdy=0 on every cycle.
- ARB_MIN, REQ_CNT=4: i_vld=4'b1010, i_rdy=1 -> grant idx1 only; o_idx=1 one cycle later. Then i_vld=4'b1000 -> o_idx=3.
- ARB_RR, all four requesters valid every cycle, i_rdy=1 -> o_idx sequence 0,1,2,3,0,1 with o_vld=1 each cycle after the first.
- Backpressure, ARB_RR: i_rdy=0 for 3 cycles with o_vld=1 -> o_dat/o_idx stable and o_rdy=0. Set i_rdy=1 -> drain and new accept in the same cycle; no beat lost or duplicated; the scoreboard matches all payloads.
- Wrap and sparse requests, ARB_RR: pointer=3, i_vld=4'b0101 -> idx0 wins; pointer becomes 1; next winner is idx2.
- CM_ARB_PKT_LOCK_EN, ARB_RR: req0 sends a 3-beat packet (last on beat 3) with an idle cycle after beat 1 while req1 is valid throughout -> o_idx=0,0,0 then 1; req1 is never granted mid-packet.
